// File: rtl/clock_button_conditioner.sv
// clock_button_conditioner
//
// Conditioning stage in front of the 32768 Hz wall-clock counter. The raw
// active-low HH/MM/SS/SAFE buttons are synchronised and debounced. Each HH/MM/SS
// press becomes a set-request that stays pending until the counter's sampling
// tick consumes it. SAFE is passed on as a debounced level.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   : HH and MM auto-repeat while held. A repeat FSM counts ticks
//               through HOLD_TICKS and then every REPEAT_TICKS.
//   undefined : HH and MM behave like SS, giving one request per press.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change (1..1023)
//   HOLD_TICKS      : ticks held before auto-repeat starts (1..15)
//   REPEAT_TICKS    : ticks between auto-repeat requests (1..15)
//
// Ports
//   clk        in  system clock (32768 Hz)
//   rst        in  synchronous active-high reset
//   tick       in  one-cycle strobe; the counter samples requests in this cycle
//   btn_*_n    in  raw asynchronous buttons, 0 = pressed
//   req_hh/mm/ss out pending set-requests (registered)
//   safe_mode  out debounced SAFE level, 1 = pressed (registered)
//
// Handshake: a req_* flag is a level-valid. The downstream tick acts as a
// one-cycle ready. A request is consumed on any cycle where tick is high,
// unless a new press or repeat arrives in that same cycle. In that case the
// flag stays high, so the new request is what remains pending.
module clock_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 655,
  parameter int unsigned HOLD_TICKS      = 2,
  parameter int unsigned REPEAT_TICKS    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_hh_n,
  input  logic btn_mm_n,
  input  logic btn_ss_n,
  input  logic btn_safe_n,
  output logic req_hh,
  output logic req_mm,
  output logic req_ss,
  output logic safe_mode
);

  localparam int CW = 10;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = HH, 1 = MM, 2 = SS, 3 = SAFE.
  logic [3:0]    raw_n;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    db_q, db_d;          // debounced, active-low like the inputs
  logic [2:0]    db_prev_q, db_prev_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [2:0]    press_edge;
  logic [2:0]    req_q, req_d;
  logic [1:0]    rep_evt;

  assign raw_n = {btn_safe_n, btn_ss_n, btn_mm_n, btn_hh_n};

  // Front end: the counter runs only while the synced value disagrees with the
  // debounced value. The debounced value flips on the last counted cycle.
  always_comb begin
    sync1_d   = raw_n;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q[2:0];
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The press edge is seen one cycle after the debounced value falls.
  assign press_edge = db_prev_q & ~db_q[2:0];

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} rep_state_e;

  localparam logic [3:0] HT_LAST = 4'(HOLD_TICKS - 1);
  localparam logic [3:0] RT_LAST = 4'(REPEAT_TICKS - 1);

  rep_state_e st_q [2];
  rep_state_e st_d [2];
  logic [3:0] tcnt_q [2];
  logic [3:0] tcnt_d [2];

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      tcnt_d[i] = tcnt_q[i];
      if (db_q[i]) begin
        // A release wins over a same-cycle tick, and no event is raised.
        st_d[i]   = ST_IDLE;
        tcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            if (press_edge[i]) begin
              st_d[i]   = ST_HOLD;
              tcnt_d[i] = '0;
            end
          end
          ST_HOLD: begin
            if (tick) begin
              if (tcnt_q[i] == HT_LAST) begin
                st_d[i]    = ST_REPEAT;
                rep_evt[i] = 1'b1;
                tcnt_d[i]  = '0;
              end else begin
                tcnt_d[i] = tcnt_q[i] + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (tick) begin
              if (tcnt_q[i] == RT_LAST) begin
                rep_evt[i] = 1'b1;
                tcnt_d[i]  = '0;
              end else begin
                tcnt_d[i] = tcnt_q[i] + 1'b1;
              end
            end
          end
          default: begin
            st_d[i]   = ST_IDLE;
            tcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        st_q[i]   <= ST_IDLE;
        tcnt_q[i] <= '0;
      end else begin
        st_q[i]   <= st_d[i];
        tcnt_q[i] <= tcnt_d[i];
      end
    end
  end
`else
  assign rep_evt = '0;
`endif

  // Request flag: a new request (press or repeat) beats consumption by tick.
  always_comb begin
    req_d = req_q;
    for (int i = 0; i < 3; i++) begin
      if (press_edge[i] || (i < 2 && rep_evt[i % 2])) begin
        req_d[i] = 1'b1;
      end else if (tick) begin
        req_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      db_prev_q <= '1;
      req_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      req_q     <= req_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign req_hh    = req_q[0];
  assign req_mm    = req_q[1];
  assign req_ss    = req_q[2];
  assign safe_mode = ~db_q[3];

endmodule

// File: tb/tb_clock_button_conditioner.sv
// Directed testbench for clock_button_conditioner. It uses DEBOUNCE_CYCLES=4,
// HOLD_TICKS=2 and REPEAT_TICKS=1. The expected values follow
// BTN_AUTOREPEAT_EN when that macro is defined.
module tb_clock_button_conditioner;

  logic clk;
  logic rst;
  logic tick;
  logic btn_hh_n, btn_mm_n, btn_ss_n, btn_safe_n;
  logic req_hh, req_mm, req_ss, safe_mode;

  int total_checks;
  int pass_checks;

  clock_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_TICKS     (2),
    .REPEAT_TICKS   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_hh_n  (btn_hh_n),
    .btn_mm_n  (btn_mm_n),
    .btn_ss_n  (btn_ss_n),
    .btn_safe_n(btn_safe_n),
    .req_hh    (req_hh),
    .req_mm    (req_mm),
    .req_ss    (req_ss),
    .safe_mode (safe_mode)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks. Inputs change and outputs are sampled 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_checks++;
    assert (obs === exp) pass_checks++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  logic       exp_b;
  logic [7:0] bounce_pat;

  initial begin
    total_checks = 0;
    pass_checks  = 0;
    rst        = 1'b1;
    tick       = 1'b0;
    btn_hh_n   = 1'b0;
    btn_mm_n   = 1'b0;
    btn_ss_n   = 1'b0;
    btn_safe_n = 1'b0;

    // Reset with all buttons pressed
    step(2);
    chk("rst_req_hh", req_hh, 1'b0);
    chk("rst_req_mm", req_mm, 1'b0);
    chk("rst_req_ss", req_ss, 1'b0);
    chk("rst_safe", safe_mode, 1'b0);
    rst = 1'b0;
    step(6);
    chk("post_rst_hh_edge5", req_hh, 1'b0);
    chk("post_rst_safe_on", safe_mode, 1'b1);
    step(1);
    chk("post_rst_hh_edge6", req_hh, 1'b1);
    chk("post_rst_mm_edge6", req_mm, 1'b1);
    chk("post_rst_ss_edge6", req_ss, 1'b1);

    // Release everything, then let one tick consume the pending requests
    btn_hh_n = 1'b1; btn_mm_n = 1'b1; btn_ss_n = 1'b1; btn_safe_n = 1'b1;
    step(8);
    chk("released_safe_off", safe_mode, 1'b0);
    chk("held_req_hh", req_hh, 1'b1);
    tick_pulse();
    chk("consumed_req_hh", req_hh, 1'b0);
    chk("consumed_req_mm", req_mm, 1'b0);
    chk("consumed_req_ss", req_ss, 1'b0);

    // Bounce: low 3, high 1, low 3, then high
    bounce_pat = 8'b1000_1000;  // bit i is driven in step i
    for (int i = 0; i < 16; i++) begin
      btn_mm_n = (i < 8) ? bounce_pat[i] : 1'b1;
      step(1);
      chk($sformatf("bounce_req_mm_%0d", i), req_mm, 1'b0);
      chk($sformatf("bounce_safe_%0d", i), safe_mode, 1'b0);
    end

    // Press SS and hold it for 50 cycles. A tick arrives every 10 cycles.
    btn_ss_n = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick = (c > 0 && c % 10 == 0);
      step(1);
      exp_b = (c >= 6 && c < 10);
      chk($sformatf("ss_req_c%0d", c), req_ss, exp_b);
    end
    tick = 1'b0;
    btn_ss_n = 1'b1;
    step(8);

    // Auto-repeat on HH, with a tick every 10 cycles starting at cycle 10
    btn_hh_n = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick = (c > 0 && c % 10 == 0);
      step(1);
`ifdef BTN_AUTOREPEAT_EN
      exp_b = (c >= 6 && c < 10) || (c >= 20);
`else
      exp_b = (c >= 6 && c < 10);
`endif
      chk($sformatf("hh_req_c%0d", c), req_hh, exp_b);
    end
    tick = 1'b0;

    // Release and re-press HH to get a fresh request
    btn_hh_n = 1'b1;
    step(8);
    tick_pulse();
    chk("hh_cleared_after_release", req_hh, 1'b0);
    btn_hh_n = 1'b0;
    step(6);
    chk("hh_repress_edge5", req_hh, 1'b0);
    step(1);
    chk("hh_repress_edge6", req_hh, 1'b1);
    btn_hh_n = 1'b1;
    step(8);
    tick_pulse();
    chk("hh_final_clear", req_hh, 1'b0);

    // Press edge coincides with a tick while req_mm is already 1
    btn_mm_n = 1'b0;
    step(7);
    chk("mm_first_req", req_mm, 1'b1);
    btn_mm_n = 1'b1;
    step(8);
    chk("mm_req_pending", req_mm, 1'b1);
    btn_mm_n = 1'b0;
    step(6);
    chk("mm_still_pending", req_mm, 1'b1);
    tick_pulse();
    chk("mm_edge_with_tick", req_mm, 1'b1);
    tick_pulse();
    chk("mm_consumed", req_mm, 1'b0);
    btn_mm_n = 1'b1;
    step(8);
    chk("mm_idle_end", req_mm, 1'b0);
    chk("ss_idle_end", req_ss, 1'b0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
